// File: rtl/rtc_set_ctrl_if.sv
// rtl/rtc_set_ctrl_if.sv - key, DS1302 driver and display signals of the time-set controller
interface rtc_set_ctrl_if;
    logic       key_mode;
    logic       key_next;
    logic       key_up;
    logic       key_down;
    logic [7:0] rd_hour;
    logic [7:0] rd_minute;
    logic [7:0] rd_second;
    logic [7:0] wr_hour;
    logic [7:0] wr_minute;
    logic [7:0] wr_second;
    logic       wr_req;
    logic       wr_ack;
    logic       rtc_halt;
    logic [1:0] edit_field;
    logic [5:0] blink_mask;

    modport master (
        input  key_mode, key_next, key_up, key_down,
        input  rd_hour, rd_minute, rd_second, wr_ack,
        output wr_hour, wr_minute, wr_second, wr_req,
        output rtc_halt, edit_field, blink_mask
    );

    modport slave (
        output key_mode, key_next, key_up, key_down,
        output rd_hour, rd_minute, rd_second, wr_ack,
        input  wr_hour, wr_minute, wr_second, wr_req,
        input  rtc_halt, edit_field, blink_mask
    );
endinterface

// File: rtl/rtc_set_ctrl.sv
// rtl/rtc_set_ctrl.sv - DS1302 time-set edit session: capture, BCD edit, commit handshake, blink
module rtc_set_ctrl #(
    parameter int BLINK_CNT = 12_499_999
) (
    input  logic          clk,
    input  logic          rst_n,
    rtc_set_ctrl_if.master bus
);
    localparam int CW = ($clog2(BLINK_CNT + 1) > 24) ? $clog2(BLINK_CNT + 1) : 24;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EDIT   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    hour_q, hour_d;
    logic [7:0]    minute_q, minute_d;
    logic [7:0]    second_q, second_d;
    logic          wr_req_q, wr_req_d;
    logic          halt_q, halt_d;
    logic [1:0]    field_q, field_d;
    logic [5:0]    mask_q, mask_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    // Out-of-range or non-BCD values snap to 00 going up and to max going down.
    function automatic logic bcd_bad(input logic [7:0] v, input logic [7:0] max);
        return (v[7:4] > 4'd9) || (v[3:0] > 4'd9) || (v > max);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (bcd_bad(v, max) || v == max) return 8'h00;
        if (v[3:0] == 4'd9)              return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        if (bcd_bad(v, max) || v == 8'h00) return max;
        if (v[3:0] == 4'd0)                return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [5:0] field_mask(input logic [1:0] f);
        case (f)
            2'd1:    return 6'b110000;
            2'd2:    return 6'b001100;
            2'd3:    return 6'b000011;
            default: return 6'b000000;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        hour_d   = hour_q;
        minute_d = minute_q;
        second_d = second_q;
        wr_req_d = wr_req_q;
        halt_d   = halt_q;
        field_d  = field_q;
        cnt_d    = '0;
        phase_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                wr_req_d = 1'b0;
                halt_d   = 1'b0;
                field_d  = 2'd0;
                if (bus.key_mode) begin
                    hour_d   = {2'b00, bus.rd_hour[5:0]};
                    minute_d = {1'b0, bus.rd_minute[6:0]};
                    second_d = {1'b0, bus.rd_second[6:0]};
                    halt_d   = 1'b1;
                    field_d  = 2'd1;
                    state_d  = S_EDIT;
                end
            end
            S_EDIT: begin
                // Free-running blink; any edit key below restarts it visible.
                if (cnt_q == CW'(BLINK_CNT)) begin
                    cnt_d   = '0;
                    phase_d = ~phase_q;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    phase_d = phase_q;
                end
                if (bus.key_mode) begin
                    wr_req_d = 1'b1;
                    state_d  = S_COMMIT;
                end else if (bus.key_next) begin
                    field_d = (field_q == 2'd3) ? 2'd1 : field_q + 2'd1;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                end else if (bus.key_up || bus.key_down) begin
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    if (bus.key_up != bus.key_down) begin
                        case (field_q)
                            2'd1: hour_d   = bus.key_up ? bcd_inc(hour_q, 8'h23)   : bcd_dec(hour_q, 8'h23);
                            2'd2: minute_d = bus.key_up ? bcd_inc(minute_q, 8'h59) : bcd_dec(minute_q, 8'h59);
                            2'd3: second_d = bus.key_up ? bcd_inc(second_q, 8'h59) : bcd_dec(second_q, 8'h59);
                            default: ;
                        endcase
                    end
                end
            end
            S_COMMIT: begin
                if (bus.wr_ack) begin
                    wr_req_d = 1'b0;
                    halt_d   = 1'b0;
                    field_d  = 2'd0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        mask_d = (state_d == S_EDIT && phase_d) ? field_mask(field_d) : 6'b000000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            hour_q   <= 8'h00;
            minute_q <= 8'h00;
            second_q <= 8'h00;
            wr_req_q <= 1'b0;
            halt_q   <= 1'b0;
            field_q  <= 2'd0;
            mask_q   <= 6'b000000;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hour_q   <= hour_d;
            minute_q <= minute_d;
            second_q <= second_d;
            wr_req_q <= wr_req_d;
            halt_q   <= halt_d;
            field_q  <= field_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
        end
    end

    assign bus.wr_hour    = hour_q;
    assign bus.wr_minute  = minute_q;
    assign bus.wr_second  = second_q;
    assign bus.wr_req     = wr_req_q;
    assign bus.rtc_halt   = halt_q;
    assign bus.edit_field = field_q;
    assign bus.blink_mask = mask_q;
endmodule
